// File: rtl/mssd_pkg.sv
// Shared state type, field widths and payload alignment helper for the
// mssd serial link transmitter.
package mssd_pkg;

    typedef enum logic [2:0] {IDLE, START, HDR, DATA, GAP} state_t;

    localparam int HDR_BITS    = 6;
    localparam int CH_W        = 2;
    localparam int LEN_W       = 4;
    localparam int MAX_PAYLOAD = 15;
    // Header plus payload. The start bit is not stored: it comes from the START state.
    localparam int PISO_W      = CH_W + LEN_W + MAX_PAYLOAD;

    // Left-justify the N live payload bits so bit N-1 sits right after len[0].
    function automatic logic [MAX_PAYLOAD-1:0] align_payload(
        input logic [MAX_PAYLOAD-1:0] data,
        input logic [LEN_W-1:0]       len
    );
        return data << (LEN_W'(MAX_PAYLOAD) - len);
    endfunction

endpackage

// File: rtl/mssd_piso.sv
// Parallel-load, shift-left register; the MSB is the next bit for the line.
module mssd_piso
    import mssd_pkg::*;
#(
    parameter int W = PISO_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign q_next[gi] = load ? din[gi] : (shift ? 1'b0 : q_reg[gi]);
            end else begin : g_upper
                assign q_next[gi] = load ? din[gi] : (shift ? q_reg[gi-1] : q_reg[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign msb = q_reg[W-1];

endmodule

// File: rtl/mssd_serial_tx.sv
// Serial frame transmitter: start bit, channel, length, then N payload bits
// MSB first, followed by GAP forced idle cycles.
module mssd_serial_tx #(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_ch,
    input  logic [3:0]  in_len,
    input  logic [14:0] in_data,
    output logic        sout,
    output logic        busy,
    output logic        done
);
    import mssd_pkg::*;

    // The GAP parameter hides the enum literal of the same name, so the gap
    // state is always written package-qualified.
    localparam bit         HAS_GAP  = (GAP > 0);
    localparam logic [3:0] GAP_LOAD = 4'(GAP);
    localparam logic [2:0] HDR_LAST = 3'(HDR_BITS - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [2:0]        hdr_cnt_reg;
    logic [LEN_W-1:0]  data_cnt_reg;
    logic [LEN_W-1:0]  gap_cnt_reg;
    logic              done_reg;

    logic              accept;
    logic              hdr_last;
    logic              data_last;
    logic              piso_shift;
    logic              piso_msb;
    logic [PISO_W-1:0] piso_din;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign hdr_last   = (state_reg == HDR) && (hdr_cnt_reg == HDR_LAST);
    assign data_last  = (state_reg == DATA) && (data_cnt_reg == 4'd1);
    assign piso_shift = (state_reg == HDR) || (state_reg == DATA);
    assign piso_din   = {in_ch, in_len, align_payload(in_data, in_len)};

    mssd_piso #(.W(PISO_W)) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (piso_shift),
        .din   (piso_din),
        .msb   (piso_msb)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (in_valid) state_next = START;
            START: state_next = HDR;
            HDR: begin
                // data_cnt_reg still holds N here, so zero means skip DATA.
                if (hdr_last) begin
                    if (data_cnt_reg != '0) state_next = DATA;
                    else if (HAS_GAP)       state_next = mssd_pkg::GAP;
                    else                    state_next = IDLE;
                end
            end
            DATA: begin
                if (data_last) begin
                    if (HAS_GAP) state_next = mssd_pkg::GAP;
                    else         state_next = IDLE;
                end
            end
            mssd_pkg::GAP: if (gap_cnt_reg == 4'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hdr_cnt_reg  <= '0;
            data_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (hdr_last && (data_cnt_reg == '0)) || data_last;

            if (accept) begin
                data_cnt_reg <= in_len;
            end else if ((state_reg == DATA) && !data_last) begin
                data_cnt_reg <= data_cnt_reg - 4'd1;
            end

            if (state_reg == HDR) begin
                hdr_cnt_reg <= hdr_last ? 3'd0 : hdr_cnt_reg + 3'd1;
            end

            if ((state_next == mssd_pkg::GAP) && (state_reg != mssd_pkg::GAP)) begin
                gap_cnt_reg <= GAP_LOAD;
            end else if (state_reg == mssd_pkg::GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 4'd1;
            end
        end
    end

    always_comb begin
        sout = 1'b1;
        if (state_reg == START) begin
            sout = 1'b0;
        end else if (piso_shift) begin
            sout = piso_msb;
        end
    end

    assign in_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;

endmodule

// File: tb/tb_mssd_serial_tx.sv
// Self-checking bench for mssd_serial_tx: fixed frame table, reset and
// back-to-back corner cases, and random frames decoded off the serial line.
module tb_mssd_serial_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ch;
    logic [3:0]  in_len;
    logic [14:0] in_data;
    logic        sout;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    mssd_serial_tx #(.GAP(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_len   (in_len),
        .in_data  (in_data),
        .sout     (sout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ch;
        logic [3:0]  len;
        logic [14:0] data;
        logic [21:0] exp_bits;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Frame as the receiver expects it, built bit by bit from the field rules.
    function automatic logic [21:0] model_frame(input logic [1:0] ch, input logic [3:0] len,
                                                input logic [14:0] data);
        logic [21:0] f;
        f = '0;
        f = {f[20:0], 1'b0};
        for (int i = 1; i >= 0; i--) f = {f[20:0], ch[i]};
        for (int i = 3; i >= 0; i--) f = {f[20:0], len[i]};
        for (int i = int'(len) - 1; i >= 0; i--) f = {f[20:0], data[i]};
        return f;
    endfunction

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({name, " ready timeout"}, 32'(n), 32'd0);
    endtask

    // Hand over one frame and capture 7+len line bits starting at the start bit.
    task automatic send_frame(input logic [1:0] ch, input logic [3:0] len, input logic [14:0] data,
                              input string name, output logic [21:0] got, output logic ok);
        int bad;
        wait_ready(name);
        in_valid = 1'b1;
        in_ch    = ch;
        in_len   = len;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
        in_ch    = 2'($urandom);
        in_len   = 4'($urandom);
        in_data  = 15'($urandom);
        got = '0;
        bad = 0;
        for (int k = 0; k < 7 + int'(len); k++) begin
            got = {got[20:0], sout};
            if (done || !busy || in_ready) bad++;
            @(negedge clk);
        end
        if (!done || !sout) bad++;
        @(negedge clk);
        if (done) bad++;
        ok = (bad == 0);
    endtask

    initial begin
        logic [21:0] got;
        logic        ok;
        int          starts[$];
        logic        prev_ready;
        logic [21:0] got2;
        int          dn;
        logic [1:0]  rch;
        logic [3:0]  rlen;
        logic [14:0] rdata;
        logic [14:0] mask;
        logic [21:0] exp_dec;
        int          sp;

        vecs[0] = '{2'd2, 4'd5,  15'h0016, 22'b010010110110};
        vecs[1] = '{2'd3, 4'd0,  15'h0000, 22'b0110000};
        vecs[2] = '{2'd1, 4'd15, 15'h7FFF, 22'b0011111111111111111111};
        vecs[3] = '{2'd0, 4'd3,  15'h7FF5, 22'b0000011101};
        vecs[4] = '{2'd2, 4'd1,  15'h0000, 22'b01000010};

        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_len = '0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset: {sout, in_ready, busy, done} = 1100 every cycle.
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("idle cycle %0d", c), {28'd0, sout, in_ready, busy, done}, 32'hC);
            @(negedge clk);
        end

        foreach (vecs[i]) begin
            send_frame(vecs[i].ch, vecs[i].len, vecs[i].data, "table", got, ok);
            chk($sformatf("table %0d bits ch=%0d len=%0d", i, vecs[i].ch, vecs[i].len),
                32'(got), 32'(vecs[i].exp_bits));
            chk($sformatf("table %0d done/busy timing", i), 32'(ok), 32'd1);
        end

        // Reset and valid together: reset wins.
        wait_ready("collide");
        rst = 1'b1; in_valid = 1'b1; in_ch = 2'd1; in_len = 4'd4; in_data = 15'h5;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("reset beats valid", {28'd0, sout, in_ready, busy, done}, 32'hC);

        // Reset during the 3rd payload bit (cycle T+10).
        wait_ready("midrst");
        in_valid = 1'b1; in_ch = 2'd1; in_len = 4'd6; in_data = 15'h002B;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid-payload reset state", {28'd0, sout, in_ready, busy, done}, 32'hC);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("no done after abort", 32'(dn), 32'd0);
        send_frame(2'd3, 4'd6, 15'h002B, "after reset", got, ok);
        chk("frame after reset", 32'(got), 32'(model_frame(2'd3, 4'd6, 15'h002B)));
        chk("frame after reset timing", 32'(ok), 32'd1);

        // Back-to-back, len=15, in_valid held high.
        wait_ready("b2b");
        in_valid = 1'b1; in_ch = 2'd1; in_len = 4'd15; in_data = 15'h1234;
        prev_ready = in_ready;
        got2 = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (prev_ready && busy) starts.push_back(c);
            if (starts.size() == 1) begin
                in_ch   = 2'd2;
                in_data = 15'h5A5A;
            end
            if (starts.size() >= 2 && c - starts[1] < 22) got2 = {got2[20:0], sout};
            prev_ready = in_ready;
        end
        in_valid = 1'b0;
        sp = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
        chk("b2b start spacing", 32'(sp), 32'd24);
        chk("b2b second frame", 32'(got2), 32'(model_frame(2'd2, 4'd15, 15'h5A5A)));

        // Random frames decoded off the line as a receiver would.
        for (int t = 0; t < 20; t++) begin
            rch   = 2'($urandom);
            rlen  = 4'($urandom_range(15, 0));
            rdata = 15'($urandom);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            send_frame(rch, rlen, rdata, "random", got, ok);
            mask    = 15'((32'd1 << rlen) - 32'd1);
            exp_dec = {1'b0, rch, rlen, rdata & mask};
            chk($sformatf("random %0d ch=%0d len=%0d data=0x%0h", t, rch, rlen, rdata & mask),
                32'({got[6 + int'(rlen)], got[5 + int'(rlen) -: 2], got[3 + int'(rlen) -: 4],
                     got[14:0] & mask}),
                32'(exp_dec));
            chk($sformatf("random %0d timing", t), 32'(ok), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
